// File: rtl/acc_seq_driver.sv
// acc_seq_driver: turns a streamed operand burst into the accumulator's load/init/neg/oe control sequence
module acc_seq_driver #(
  parameter int DATA_WIDTH  = 8,
  parameter int ATTR_WIDTH  = 4,
  parameter int HOLD_CYCLES = 2,
  parameter int CNT_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  op_count,
  input  logic [ATTR_WIDTH-1:0] attr_in,
  input  logic                  abort,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_neg,
  output logic                  in_ready,
  output logic                  signal_load,
  output logic                  signal_init,
  output logic                  signal_neg,
  output logic                  signal_oe,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [ATTR_WIDTH-1:0] attr_out,
  output logic                  busy,
  output logic                  done
);
  localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, WAIT_OP, DRIVE, DONE} state_t;
  state_t state, ns;
  logic [CNT_WIDTH-1:0] rem;
  logic [HW-1:0] hcnt;
  logic first, go, accept, hold_end;
  logic ready_n, load_n, init_n, neg_n, oe_n, busy_n, done_n;
  logic [DATA_WIDTH-1:0] data_n;
  assign go       = state == IDLE && start && op_count != '0;
  assign accept   = state == WAIT_OP && in_valid && in_ready && !abort;
  assign hold_end = state == DRIVE && hcnt == '0 && !abort;
  // next state: abort beats operand capture and hold completion
  always_comb begin
    ns = abort && state != IDLE ? IDLE :
         go                     ? WAIT_OP :
         accept                 ? DRIVE :
         hold_end               ? (rem == CNT_WIDTH'(1) ? DONE : WAIT_OP) :
         state == DONE          ? IDLE : state;
  end
  // next values of the registered outputs; ready lags one cycle after a fresh start
  always_comb begin
    ready_n = ns == WAIT_OP && state != IDLE;
    load_n  = ns == DRIVE;
    init_n  = accept && first;
    neg_n   = accept ? in_neg : (ns == DRIVE && signal_neg);
    oe_n    = ns == IDLE || ns == DONE;
    busy_n  = ns != IDLE;
    done_n  = ns == DONE;
    data_n  = accept ? in_data : data_out;
  end
  // state, burst bookkeeping and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rem         <= '0;
      hcnt        <= '0;
      first       <= 1'b0;
      in_ready    <= 1'b0;
      signal_load <= 1'b0;
      signal_init <= 1'b0;
      signal_neg  <= 1'b0;
      signal_oe   <= 1'b1;
      data_out    <= '0;
      attr_out    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state <= ns;
      if (go) begin
        rem      <= op_count;
        attr_out <= attr_in;
        first    <= 1'b1;
      end
      if (accept) begin
        hcnt  <= HW'(HOLD_CYCLES - 1);
        first <= 1'b0;
      end else if (state == DRIVE && hcnt != '0) hcnt <= hcnt - HW'(1);
      if (hold_end) rem <= rem - CNT_WIDTH'(1);
      in_ready    <= ready_n;
      signal_load <= load_n;
      signal_init <= init_n;
      signal_neg  <= neg_n;
      signal_oe   <= oe_n;
      busy        <= busy_n;
      done        <= done_n;
      data_out    <= data_n;
    end
  end
endmodule

// File: tb/tb_acc_seq_driver.sv
// tb_acc_seq_driver: directed vector table plus hand-written multi-cycle sequences for acc_seq_driver
module tb_acc_seq_driver;
  logic clk = 0, rst = 1, start = 0, abort = 0, in_valid = 0, in_neg = 0;
  logic [3:0] op_count = 0, attr_in = 0, attr_out;
  logic [7:0] in_data = 0, data_out;
  logic in_ready, signal_load, signal_init, signal_neg, signal_oe, busy, done;
  int checks = 0, errors = 0;
  typedef struct {
    logic st; logic [3:0] cnt; logic [3:0] attr; logic ab; logic vl; logic [7:0] d; logic ng;
    logic [6:0] f; logic [7:0] dout; logic [3:0] ea;
  } vec_t;
  vec_t tv[$];
  always #5 clk = ~clk;
  acc_seq_driver dut (
    .clk(clk), .rst(rst), .start(start), .op_count(op_count), .attr_in(attr_in),
    .abort(abort), .in_valid(in_valid), .in_data(in_data), .in_neg(in_neg),
    .in_ready(in_ready), .signal_load(signal_load), .signal_init(signal_init),
    .signal_neg(signal_neg), .signal_oe(signal_oe), .data_out(data_out),
    .attr_out(attr_out), .busy(busy), .done(done)
  );
  function automatic vec_t mk(logic st, logic [3:0] cnt, logic [3:0] attr, logic ab, logic vl,
                              logic [7:0] d, logic ng, logic [6:0] f, logic [7:0] dout, logic [3:0] ea);
    vec_t v;
    v.st = st; v.cnt = cnt; v.attr = attr; v.ab = ab; v.vl = vl; v.d = d; v.ng = ng;
    v.f = f; v.dout = dout; v.ea = ea;
    return v;
  endfunction
  function automatic logic [18:0] obs();
    return {in_ready, signal_load, signal_init, signal_neg, signal_oe, busy, done, data_out, attr_out};
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int nx, wins, loads, inits, dones;
    logic pl;
    // flags order: ready load init neg oe busy done
    // basic burst of 4
    tv.push_back(mk(1, 4, 5, 0, 0, 0, 0, 7'b0000010, 0, 5));
    tv.push_back(mk(0, 0, 0, 0, 1, 1, 0, 7'b1000010, 0, 5));
    tv.push_back(mk(0, 0, 0, 0, 1, 1, 0, 7'b0110010, 1, 5));
    tv.push_back(mk(0, 0, 0, 0, 1, 2, 0, 7'b0100010, 1, 5));
    tv.push_back(mk(0, 0, 0, 0, 1, 2, 0, 7'b1000010, 1, 5));
    tv.push_back(mk(0, 0, 0, 0, 1, 2, 0, 7'b0100010, 2, 5));
    tv.push_back(mk(0, 0, 0, 0, 1, 3, 0, 7'b0100010, 2, 5));
    tv.push_back(mk(0, 0, 0, 0, 1, 3, 0, 7'b1000010, 2, 5));
    tv.push_back(mk(0, 0, 0, 0, 1, 3, 0, 7'b0100010, 3, 5));
    tv.push_back(mk(0, 0, 0, 0, 1, 4, 0, 7'b0100010, 3, 5));
    tv.push_back(mk(0, 0, 0, 0, 1, 4, 0, 7'b1000010, 3, 5));
    tv.push_back(mk(0, 0, 0, 0, 1, 4, 0, 7'b0100010, 4, 5));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 7'b0100010, 4, 5));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 7'b0000111, 4, 5));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 7'b0000100, 4, 5));
    // negation with a 5-cycle stall
    tv.push_back(mk(1, 2, 4'hA, 0, 0, 0, 0, 7'b0000010, 4, 4'hA));
    tv.push_back(mk(0, 0, 0, 0, 1, 10, 0, 7'b1000010, 4, 4'hA));
    tv.push_back(mk(0, 0, 0, 0, 1, 10, 0, 7'b0110010, 10, 4'hA));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 7'b0100010, 10, 4'hA));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 7'b1000010, 10, 4'hA));
    for (int i = 0; i < 5; i++) tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 7'b1000010, 10, 4'hA));
    tv.push_back(mk(0, 0, 0, 0, 1, 3, 1, 7'b0101010, 3, 4'hA));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 7'b0101010, 3, 4'hA));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 7'b0000111, 3, 4'hA));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 7'b0000100, 3, 4'hA));
    // abort in the second hold cycle of operand 2
    tv.push_back(mk(1, 3, 3, 0, 0, 0, 0, 7'b0000010, 3, 3));
    tv.push_back(mk(0, 0, 0, 0, 1, 7, 0, 7'b1000010, 3, 3));
    tv.push_back(mk(0, 0, 0, 0, 1, 7, 0, 7'b0110010, 7, 3));
    tv.push_back(mk(0, 0, 0, 0, 1, 8, 0, 7'b0100010, 7, 3));
    tv.push_back(mk(0, 0, 0, 0, 1, 8, 0, 7'b1000010, 7, 3));
    tv.push_back(mk(0, 0, 0, 0, 1, 8, 0, 7'b0100010, 8, 3));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 7'b0100010, 8, 3));
    tv.push_back(mk(0, 0, 0, 1, 0, 0, 0, 7'b0000100, 8, 3));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 7'b0000100, 8, 3));
    // single operand after abort
    tv.push_back(mk(1, 1, 6, 0, 0, 0, 0, 7'b0000010, 8, 6));
    tv.push_back(mk(0, 0, 0, 0, 1, 7, 0, 7'b1000010, 8, 6));
    tv.push_back(mk(0, 0, 0, 0, 1, 7, 0, 7'b0110010, 7, 6));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 7'b0100010, 7, 6));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 7'b0000111, 7, 6));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 7'b0000100, 7, 6));
    // ignored starts: zero count, then restart while busy
    tv.push_back(mk(1, 0, 9, 0, 0, 0, 0, 7'b0000100, 7, 6));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 7'b0000100, 7, 6));
    tv.push_back(mk(1, 2, 2, 0, 0, 0, 0, 7'b0000010, 7, 2));
    tv.push_back(mk(1, 5, 4'hF, 0, 1, 1, 0, 7'b1000010, 7, 2));
    tv.push_back(mk(1, 5, 4'hF, 0, 1, 1, 0, 7'b0110010, 1, 2));
    tv.push_back(mk(0, 0, 0, 0, 1, 2, 0, 7'b0100010, 1, 2));
    tv.push_back(mk(0, 0, 0, 0, 1, 2, 0, 7'b1000010, 1, 2));
    tv.push_back(mk(0, 0, 0, 0, 1, 2, 0, 7'b0100010, 2, 2));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 7'b0100010, 2, 2));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 7'b0000111, 2, 2));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 7'b0000100, 2, 2));
    cyc();
    cyc();
    chk("reset_state", 32'(obs()), {13'b0, 7'b0000100, 8'h00, 4'h0});
    rst = 0;
    cyc();
    foreach (tv[i]) begin
      start = tv[i].st; op_count = tv[i].cnt; attr_in = tv[i].attr; abort = tv[i].ab;
      in_valid = tv[i].vl; in_data = tv[i].d; in_neg = tv[i].ng;
      cyc();
      chk($sformatf("row%0d", i), 32'(obs()), 32'({tv[i].f, tv[i].dout, tv[i].ea}));
    end
    start = 0; abort = 0; in_valid = 0; in_neg = 0;
    // async reset while driving
    start = 1; op_count = 1; attr_in = 7;
    cyc();
    start = 0; in_valid = 1; in_data = 8'h55;
    cyc();
    cyc();
    chk("pre_rst_load", 32'(signal_load), 1);
    #3 rst = 1;
    #1 chk("async_rst", 32'(obs()), {13'b0, 7'b0000100, 8'h00, 4'h0});
    in_valid = 0;
    cyc();
    rst = 0;
    start = 1; op_count = 1; attr_in = 4'hC;
    cyc();
    start = 0; in_valid = 1; in_data = 8'hFF;
    cyc();
    cyc();
    chk("ff_drive", 32'(obs()), {13'b0, 7'b0110010, 8'hFF, 4'hC});
    in_valid = 0;
    cyc();
    cyc();
    chk("ff_done", 32'(obs()), {13'b0, 7'b0000111, 8'hFF, 4'hC});
    cyc();
    // maximum burst of 15 back-to-back operands
    start = 1; op_count = 15; attr_in = 1;
    cyc();
    start = 0;
    nx = 1; wins = 0; loads = 0; inits = 0; dones = 0; pl = 0;
    for (int c = 0; c < 150 && dones == 0; c++) begin
      in_valid = 1; in_data = 8'(nx);
      cyc();
      if (signal_load && !pl) begin
        chk($sformatf("win%0d_data", nx), 32'(data_out), 32'(nx));
        wins++;
        nx++;
      end
      if (signal_load) loads++;
      if (signal_init) begin
        inits++;
        chk("init_first_op", 32'(data_out), 1);
      end
      if (done) dones++;
      pl = signal_load;
    end
    in_valid = 0;
    chk("max_windows", 32'(wins), 15);
    chk("max_load_cycles", 32'(loads), 30);
    chk("max_inits", 32'(inits), 1);
    chk("max_done", 32'(dones), 1);
    chk("max_last_data", 32'(data_out), 15);
    cyc();
    chk("max_idle", 32'({signal_oe, busy, done}), 3'b100);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/acc_seq_driver.md
Name: acc_seq_driver

Overview:
Driver-side sequencer for the accumulator's load/init/neg/oe interface. It accepts a burst of operands over a valid/ready stream. It then emits the cycle-exact control sequence the accumulator consumes: init on the first operand, each operand held stable for HOLD_CYCLES, and oe gated around the burst. It sits between a host/command source and the accumulator, replacing hand-written stimulus tasks in system-level use.

Parameters:
DATA_WIDTH, 8, width of operand and data_out
ATTR_WIDTH, 4, width of attribute passed to the accumulator
HOLD_CYCLES, 2, clock cycles each operand is presented (>=1)
CNT_WIDTH, 4, width of op_count; burst length 1..2^CNT_WIDTH-1

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
start  in  1  begin a burst (sampled in IDLE only)
op_count  in  CNT_WIDTH  number of operands in burst, latched on start
attr_in  in  ATTR_WIDTH  attribute, latched on start
abort  in  1  synchronous burst cancel
in_valid  in  1  operand available
in_data  in  DATA_WIDTH  operand value
in_neg  in  1  operand is to be subtracted
in_ready  out  1  driver accepts operand this cycle
signal_load  out  1  accumulator load strobe
signal_init  out  1  accumulator clear-and-load (first operand only)
signal_neg  out  1  negate current operand
signal_oe  out  1  accumulator output enable
data_out  out  DATA_WIDTH  operand to accumulator
attr_out  out  ATTR_WIDTH  latched attribute
busy  out  1  burst in progress
done  out  1  one-cycle pulse at burst completion

Behaviour:
- Reset (async, rst=1) values: state IDLE; signal_load=0, signal_init=0, signal_neg=0, signal_oe=1, data_out=0, attr_out=0, in_ready=0, busy=0, done=0. All outputs are registered.
- States: IDLE, WAIT_OP, DRIVE, DONE.
- IDLE: oe=1, busy=0.
  - start=1 with op_count!=0: latch op_count into remaining and attr_in into attr_out; set first=1; go WAIT_OP.
  - start with op_count==0: ignored; no done pulse.
- WAIT_OP: in_ready=1, busy=1, oe=0, load=0, init=0.
  - On in_valid&in_ready at edge m: capture in_data to data_out and in_neg to signal_neg; load hold counter with HOLD_CYCLES-1; go DRIVE.
- DRIVE: in_ready=0; load=1 for exactly HOLD_CYCLES cycles after edge m.
  - data_out and signal_neg are stable for the whole hold.
  - signal_init=1 only in the first DRIVE cycle of the first operand; first clears afterwards.
  - Hold end: decrement remaining. If the result is 0, go DONE; otherwise go WAIT_OP.
  - load drops to 0 for at least one cycle between operands. This is the stall indication for the accumulator.
- DONE: exactly 1 cycle with done=1, load=0, neg=0, oe=1, busy=1; then IDLE.
  - data_out retains the last operand until the next capture.
- Latency:
  - start at edge k gives in_ready=1 after edge k+1.
  - Operand accept at edge m gives load=1 after edge m.
  - The last hold ends at edge m+HOLD_CYCLES; done=1 in the following cycle.
- start while busy: ignored.
- in_valid in IDLE or DRIVE: not accepted; in_ready=0.
- abort (any non-IDLE state): next edge forces IDLE with load/init/neg=0, oe=1, no done pulse. abort has priority over operand capture and over hold completion.
- rst mid-burst: immediate return to reset values; the partial burst is discarded.
- attr_out holds its value from start until the next start.
- HOLD_CYCLES=1: init and load are both single-cycle; sequencing is otherwise identical.

Test Plan:
- Basic burst: rst pulse, then start with op_count=4, attr_in=4'h5; feed 1,2,3,4 back-to-back with in_neg=0 → four load windows of 2 cycles with data_out 1,2,3,4. init=1 only in the first cycle of operand 1. One idle load cycle between operands. done pulses once; attr_out=5; oe is 0 during the burst and 1 after.
- Negation/stall: op_count=2, operands 10 (neg=0) and 3 (neg=1); in_valid held low 5 cycles between them → in_ready stays 1 and load stays 0 during the stall. signal_neg=1 only during the 3's window; done follows.
- Abort: op_count=3; assert abort in the second cycle of operand 2's hold → IDLE next edge; load=0, oe=1, no done; a following start with op_count=1 and operand 7 completes normally with init=1.
- Ignored starts: start with op_count=0 → stays IDLE, no done. start pulsed mid-burst → burst length and attr_out unchanged.
- Async reset: assert rst asynchronously, mid-clock, during DRIVE → outputs go to reset values before the next edge. Release, then a full burst of 1 operand (value 255) works; data_out=8'hFF.
- Single operand / max count: op_count=15 with operands 1..15 → 15 windows, init only on the first, done after the 15th. With op_count=1, init and done both occur within one burst.
